full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Parameterised full adder computing {Cout, Sum} = A + B + Cin.
- Provides a zero-latency combinational result for datapath use and a one-cycle registered copy with valid and overflow flags for pipelined consumers.
- Default WIDTH=1 gives the classic 1-bit full adder.
- Leaf arithmetic block instantiated inside larger adders and ALUs.

Parameters:
- WIDTH, 1, operand/sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst_n  input  1  synchronous active-low reset.
- A  input  WIDTH  operand A (unsigned, or two's complement for the overflow flag).
- B  input  WIDTH  operand B.
- Cin  input  1  carry in.
- in_valid  input  1  qualifies A/B/Cin for capture into the output register.
- Sum  output  WIDTH  combinational sum bits.
- Cout  output  1  combinational carry out.
- Sum_q  output  WIDTH  registered Sum.
- Cout_q  output  1  registered Cout.
- Ovf_q  output  1  registered signed overflow.
- out_valid  output  1  Sum_q/Cout_q/Ovf_q hold a fresh result.

Behaviour:
- Combinational path:
  - {Cout, Sum} = A + B + Cin, computed at WIDTH+1 bits; no truncation of the carry.
  - Bit i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i; c_0 = Cin; Cout = c_WIDTH.
  - Implement as an explicit ripple chain of per-bit generate/propagate cells.
  - Sum/Cout respond within the same delta cycle as an input change; they are independent of clk and rst_n.
  - No X propagation from unused logic: all inputs known implies all outputs known.
- Overflow (internal, combinational):
  - ovf = c_WIDTH ^ c_{WIDTH-1}.
  - For WIDTH=1, c_{WIDTH-1} is Cin, so ovf = Cout ^ Cin.
- Registered path, on each rising clk edge:
  - If rst_n=0: Sum_q=0, Cout_q=0, Ovf_q=0, out_valid=0. Reset has priority over in_valid.
  - Else if in_valid=1: Sum_q<=Sum, Cout_q<=Cout, Ovf_q<=ovf, out_valid<=1.
  - Else: Sum_q, Cout_q and Ovf_q hold their values; out_valid<=0.
- Latency:
  - Combinational outputs: 0 cycles.
  - Registered outputs: 1 cycle after the in_valid edge.
- Throughput: one result per cycle. Back-to-back in_valid pulses produce back-to-back out_valid pulses.
- No backpressure: the consumer must sample the result while out_valid=1.
- Reset asserted mid-stream drops any result being captured on that edge.
- Input changes between clock edges affect only Sum/Cout, never the registers.

Test Plan:
- WIDTH=1, exhaustive combinational sweep, 10 time units per vector, {A,B,Cin} -> {Sum,Cout}:
  - 000 -> 0,0
  - 010 -> 1,0
  - 100 -> 1,0
  - 110 -> 0,1
  - 001 -> 1,0
  - 011 -> 0,1
  - 101 -> 0,1
  - 111 -> 1,1
- WIDTH=1 registered path: rst_n=0 for 2 cycles -> all _q outputs 0 and out_valid=0. Then in_valid=1 with A=1,B=1,Cin=1 -> next edge gives Sum_q=1, Cout_q=1, Ovf_q=0, out_valid=1.
- WIDTH=8 wrap: A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1, ovf=0. A=0x7F, B=0x01, Cin=0 -> Sum=0x80, Cout=0, ovf=1.
- WIDTH=8 hold: capture A=0x12, B=0x34, Cin=1, giving Sum_q=0x47. Then in_valid=0 for 3 cycles with random inputs -> Sum_q stays 0x47, out_valid=0.
- Reset priority: rst_n=0 and in_valid=1 on the same edge -> Sum_q=0, Cout_q=0, out_valid=0. Combinational Sum still equals A+B+Cin.
- Random WIDTH=16: 1000 random vectors with random in_valid -> combinational and registered results match a reference model exactly.

Source files
------------

// File: rtl/full_adder.sv
// Parameterised ripple-carry full adder: zero-latency {Cout, Sum} = A + B + Cin plus a
// one-cycle registered copy carrying valid and two's-complement overflow flags.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH-1:0] Sum_q,
    output logic             Cout_q,
    output logic             Ovf_q,
    output logic             out_valid
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_gen;
    logic [WIDTH-1:0] w_prop;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_valid;

    assign w_carry[0] = Cin;

    // Per-bit generate/propagate cell; carry ripples from bit 0 upward
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_gen[i]       = A[i] & B[i];
        assign w_prop[i]      = A[i] ^ B[i];
        assign w_sum[i]       = w_prop[i] ^ w_carry[i];
        assign w_carry[i + 1] = w_gen[i] | (w_prop[i] & w_carry[i]);
    end

    // Signed overflow: carry into the MSB differs from carry out of it (Cin when WIDTH=1)
    assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    assign Sum  = w_sum;
    assign Cout = w_carry[WIDTH];

    // Output register: reset wins over capture, idle cycles hold data and drop valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum   <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_sum   <= w_sum;
            r_cout  <= w_carry[WIDTH];
            r_ovf   <= w_ovf;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign Sum_q     = r_sum;
    assign Cout_q    = r_cout;
    assign Ovf_q     = r_ovf;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH=1, 8 and 16 using hand-computed tables.
module tb_full_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [0:0]  a1, b1, sum1, sq1;
    logic        cin1, v1, cout1, cq1, oq1, ov1;
    logic [7:0]  a8, b8, sum8, sq8;
    logic        cin8, v8, cout8, cq8, oq8, ov8;
    logic [15:0] a16, b16, sum16, sq16;
    logic        cin16, v16, cout16, cq16, oq16, ov16;

    int errors = 0;
    int checks = 0;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1), .in_valid(v1),
        .Sum(sum1), .Cout(cout1), .Sum_q(sq1), .Cout_q(cq1), .Ovf_q(oq1), .out_valid(ov1)
    );
    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .in_valid(v8),
        .Sum(sum8), .Cout(cout8), .Sum_q(sq8), .Cout_q(cq8), .Ovf_q(oq8), .out_valid(ov8)
    );
    full_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(cin16), .in_valid(v16),
        .Sum(sum16), .Cout(cout16), .Sum_q(sq16), .Cout_q(cq16), .Ovf_q(oq16), .out_valid(ov16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t t1[8];
    vec_t t8[6];

    logic [16:0] ref17;
    logic [15:0] e_sq16;
    logic        e_cq16, e_oq16, e_ov16;

    initial begin
        // {a, b, cin, sum, cout, ovf}
        t1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        t1[1] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0};
        t1[2] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
        t1[3] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b1};
        t1[4] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1};
        t1[5] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0};
        t1[6] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0};
        t1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0};

        t8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        t8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        t8[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        t8[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        t8[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        t8[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; v1 = 1'b1;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; v8 = 1'b1;
        a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0; v16 = 1'b1;

        // Reset held for two edges with in_valid high
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w1_sum_q", 32'(sq1), 32'd0);
        chk("rst_w1_cout_q", 32'(cq1), 32'd0);
        chk("rst_w1_ovf_q", 32'(oq1), 32'd0);
        chk("rst_w1_valid", 32'(ov1), 32'd0);
        chk("rst_w8_valid", 32'(ov8), 32'd0);
        chk("rst_w16_valid", 32'(ov16), 32'd0);

        @(negedge clk);
        rst_n = 1'b1; v8 = 1'b0; v16 = 1'b0;

        // WIDTH=1 exhaustive sweep, each vector also captured into the register
        for (int i = 0; i < 8; i++) begin
            a1 = t1[i].a[0:0]; b1 = t1[i].b[0:0]; cin1 = t1[i].cin; v1 = 1'b1;
            #1;
            chk($sformatf("w1_sum[%0d]", i), 32'(sum1), 32'(t1[i].sum[0]));
            chk($sformatf("w1_cout[%0d]", i), 32'(cout1), 32'(t1[i].cout));
            @(posedge clk);
            #1;
            chk($sformatf("w1_sum_q[%0d]", i), 32'(sq1), 32'(t1[i].sum[0]));
            chk($sformatf("w1_cout_q[%0d]", i), 32'(cq1), 32'(t1[i].cout));
            chk($sformatf("w1_ovf_q[%0d]", i), 32'(oq1), 32'(t1[i].ovf));
            chk($sformatf("w1_valid[%0d]", i), 32'(ov1), 32'd1);
            @(negedge clk);
        end
        v1 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        @(posedge clk);
        #1;
        chk("w1_idle_valid", 32'(ov1), 32'd0);
        chk("w1_idle_hold", 32'({cq1, oq1, sq1}), 32'b101);
        @(negedge clk);

        // WIDTH=8 directed vectors, ending with 0x12+0x34+1 for the hold test
        for (int i = 0; i < 6; i++) begin
            a8 = t8[i].a; b8 = t8[i].b; cin8 = t8[i].cin; v8 = 1'b1;
            #1;
            chk($sformatf("w8_sum[%0d]", i), 32'(sum8), 32'(t8[i].sum));
            chk($sformatf("w8_cout[%0d]", i), 32'(cout8), 32'(t8[i].cout));
            @(posedge clk);
            #1;
            chk($sformatf("w8_sum_q[%0d]", i), 32'(sq8), 32'(t8[i].sum));
            chk($sformatf("w8_cout_q[%0d]", i), 32'(cq8), 32'(t8[i].cout));
            chk($sformatf("w8_ovf_q[%0d]", i), 32'(oq8), 32'(t8[i].ovf));
            chk($sformatf("w8_valid[%0d]", i), 32'(ov8), 32'd1);
            @(negedge clk);
        end

        // Hold: random inputs with in_valid low must not disturb the register
        for (int i = 0; i < 3; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); v8 = 1'b0;
            #1;
            chk($sformatf("w8_hold_comb[%0d]", i), 32'({cout8, sum8}),
                32'(9'(a8) + 9'(b8) + 9'(cin8)));
            @(posedge clk);
            #1;
            chk($sformatf("w8_hold_sum_q[%0d]", i), 32'(sq8), 32'h47);
            chk($sformatf("w8_hold_valid[%0d]", i), 32'(ov8), 32'd0);
            @(negedge clk);
        end

        // Reset priority over a simultaneous capture
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; v8 = 1'b1; rst_n = 1'b0;
        #1;
        chk("rstpri_comb_sum", 32'(sum8), 32'h47);
        @(posedge clk);
        #1;
        chk("rstpri_sum_q", 32'(sq8), 32'h00);
        chk("rstpri_cout_q", 32'(cq8), 32'd0);
        chk("rstpri_valid", 32'(ov8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; v8 = 1'b0;

        // WIDTH=16 random run against an independent reference
        e_sq16 = 16'h0000; e_cq16 = 1'b0; e_oq16 = 1'b0; e_ov16 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            cin16 = 1'($urandom); v16 = 1'($urandom);
            if (i % 97 == 5) begin
                a16 = 16'h7FFF; b16 = 16'h0000; cin16 = 1'b1;
            end
            ref17 = 17'(a16) + 17'(b16) + 17'(cin16);
            #1;
            chk("w16_comb", 32'({cout16, sum16}), 32'(ref17));
            if (v16) begin
                e_sq16 = ref17[15:0];
                e_cq16 = ref17[16];
                e_oq16 = (a16[15] == b16[15]) && (ref17[15] != a16[15]);
            end
            e_ov16 = v16;
            @(posedge clk);
            #1;
            chk("w16_reg", 32'({e_ov16, e_oq16, e_cq16, e_sq16}) ^ 32'({ov16, oq16, cq16, sq16}), 32'd0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
